// File: rtl/ebike_pkg.sv
// Shared types and defaults for the e-bike drive path.
package ebike_pkg;
    localparam int DRV_W         = 12;
    localparam int PWM_DEAD_DFLT = 6;

    typedef logic [DRV_W-1:0] pwm_t;
endpackage

// File: rtl/dead_time_gen.sv
// Turns a raw PWM level into a complementary gate pair with a dead gap on every switch.
module dead_time_gen #(
    parameter int DEAD = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic coast,
    output logic pwm_hi,
    output logic pwm_lo
);
    localparam int              DT_W    = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
    localparam logic [DT_W-1:0] DT_INIT = DT_W'(DEAD);

    logic [DT_W-1:0] dt;
    logic            raw_q;

    // Every path except the settled one drives both gates low, so no overlap can escape.
    always_ff @(posedge clk) begin
        if (rst) begin
            dt     <= DT_INIT;
            raw_q  <= 1'b0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (coast) begin
            dt     <= DT_INIT;
            raw_q  <= raw;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (raw != raw_q) begin
            dt     <= DT_INIT;
            raw_q  <= raw;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else if (dt != '0) begin
            dt     <= dt - DT_W'(1);
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            pwm_hi <= raw_q;
            pwm_lo <= ~raw_q;
        end
    end
endmodule

// File: rtl/drv_pwm.sv
// PID magnitude to dead-time-protected half-bridge PWM, with a once-per-period sync strobe.
module drv_pwm
    import ebike_pkg::*;
#(
    parameter int CNT_W    = DRV_W,
    parameter int DEAD     = PWM_DEAD_DFLT,
    parameter bit FAST_SIM = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  pwm_t drv_mag,
    input  logic coast,
    output logic pwm_hi,
    output logic pwm_lo,
    output logic pwm_synch
);
    localparam int DEAD_EFF = FAST_SIM ? 1 : DEAD;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_q;
    logic             cnt_last;
    logic             raw;

    assign cnt_last = (cnt == '1);
    assign raw      = (cnt < duty_q);

    // Duty is latched on the last count so it applies from cnt==0 for a whole period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            duty_q    <= '0;
            pwm_synch <= 1'b0;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            pwm_synch <= cnt_last;
            if (cnt_last)
                duty_q <= CNT_W'(drv_mag);
        end
    end

    dead_time_gen #(
        .DEAD (DEAD_EFF)
    ) u_dt (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw),
        .coast  (coast),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );
endmodule

// File: tb/tb_drv_pwm.sv
// Directed bench for drv_pwm: per-period gate widths, sync cadence, coast and reset recovery.
module tb_drv_pwm;
    logic        clk = 1'b0;
    logic        rst;
    logic        coast;
    logic [11:0] drv_mag;
    logic        pwm_hi, pwm_lo, pwm_synch;

    int n_vec = 0;
    int n_err = 0;
    int ovl   = 0;

    drv_pwm #(
        .CNT_W    (12),
        .DEAD     (6),
        .FAST_SIM (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .drv_mag   (drv_mag),
        .coast     (coast),
        .pwm_hi    (pwm_hi),
        .pwm_lo    (pwm_lo),
        .pwm_synch (pwm_synch)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (pwm_hi === 1'b1 && pwm_lo === 1'b1) ovl++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_synch(output int n);
        n = 0;
        while (pwm_synch !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // Starts in the synch cycle (cnt==0), walks one full period, ends in the next synch cycle.
    task automatic period(input string tag, input int e_hi, input int e_lo, input int e_fh,
                          input int chg_at = -1, input logic [11:0] chg_val = 12'd0);
        int hi_n, lo_n, syn_n, fh;
        hi_n = 0; lo_n = 0; syn_n = 0; fh = -1;
        for (int i = 0; i < 4096; i++) begin
            if (pwm_hi === 1'b1) begin
                hi_n++;
                if (fh < 0) fh = i;
            end
            if (pwm_lo === 1'b1) lo_n++;
            if (pwm_synch === 1'b1) syn_n++;
            if (i == chg_at) drv_mag = chg_val;
            tick();
        end
        check({tag, "_hi_width"}, hi_n, e_hi);
        check({tag, "_lo_width"}, lo_n, e_lo);
        check({tag, "_synch_cnt"}, syn_n, 1);
        check({tag, "_hi_first"}, fh, e_fh);
    endtask

    initial begin
        int n, lo_rise, low_n, hi_n, lo_n, syn_n;

        rst = 1'b1; coast = 1'b0; drv_mag = 12'd0;
        repeat (3) tick();
        check("rst_hi", pwm_hi, 0);
        check("rst_lo", pwm_lo, 0);
        check("rst_synch", pwm_synch, 0);
        rst = 1'b0;

        // duty 0: lo comes up on the 7th edge after release and stays
        lo_rise = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pwm_lo === 1'b1 && lo_rise == 0) lo_rise = k;
        end
        check("lo_rise_after_rst", lo_rise, 7);
        wait_synch(n);
        check("first_synch", n, 4086);

        drv_mag = 12'd1024;
        period("d0", 0, 4096, -1);
        period("d1024", 1017, 3065, 8);
        period("d1024_midchg", 1017, 3065, 8, 2000, 12'd3000);
        period("d3000", 2993, 1089, 8);
        check("no_overlap_a", ovl, 0);

        // coast for 20 edges in the middle of a 3000 hi phase
        repeat (500) tick();
        check("hi_before_coast", pwm_hi, 1);
        coast = 1'b1;
        tick();
        check("coast_hi", pwm_hi, 0);
        check("coast_lo", pwm_lo, 0);
        repeat (19) tick();
        coast = 1'b0;
        low_n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pwm_hi === 1'b0 && pwm_lo === 1'b0) low_n++;
        end
        check("coast_dead_edges", low_n, 6);
        tick();
        check("coast_resume_hi", pwm_hi, 1);
        wait_synch(n);
        check("coast_synch_cadence", n, 3569);

        drv_mag = 12'd4095;
        period("d3000_b", 2993, 1089, 8);
        // lo still high in cnt==0 left over from the 3000 period
        period("d4095_first", 4088, 1, 8);
        period("d4095", 4088, 0, 8, 0, 12'd3);
        period("d3_first", 0, 4085, -1);
        period("d3", 0, 4086, -1, 0, 12'd2048);
        check("no_overlap_b", ovl, 0);

        // reset pulse mid-period while hi is on
        repeat (100) tick();
        check("hi_before_rst", pwm_hi, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_hi", pwm_hi, 0);
        check("midrst_lo", pwm_lo, 0);
        check("midrst_synch", pwm_synch, 0);
        hi_n = 0; lo_n = 0; syn_n = 0;
        for (int i = 1; i < 4096; i++) begin
            tick();
            if (pwm_hi === 1'b1) hi_n++;
            if (pwm_lo === 1'b1) lo_n++;
            if (pwm_synch === 1'b1) syn_n++;
        end
        check("postrst_hi_width", hi_n, 0);
        check("postrst_lo_width", lo_n, 4089);
        check("postrst_synch_cnt", syn_n, 0);
        tick();
        check("postrst_synch", pwm_synch, 1);
        period("d2048", 2041, 2041, 8);
        check("no_overlap_c", ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
